// File: rtl/put_pkg.sv
// Shared definitions for the American put backward-induction pipeline.
// Holds the default geometry (lanes per chunk, value width, chunks per
// level), the chunk vector type, the level-sequencer state encoding and a
// helper that extracts one lane from a chunk.
package put_pkg;

  localparam int P_LANES   = 32;
  localparam int P_WIDTH   = 64;
  localparam int P_DEPTH   = 16;
  localparam int P_CHUNK_W = P_LANES * P_WIDTH;

  typedef logic [P_CHUNK_W-1:0] chunk_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Lane i of a chunk lives at [WIDTH*i +: WIDTH].
  function automatic logic [P_WIDTH-1:0] lane_of(input chunk_t c, input int unsigned i);
    return c[P_WIDTH*i +: P_WIDTH];
  endfunction

endpackage

// File: rtl/chunk_ram.sv
// Node-value store: simple dual-port RAM, one write port and one read port.
// The read is registered (1-cycle latency) and read-first, so a read and a
// write to the same chunk in one cycle returns the old contents.
// Ports:
//   clk, reset      clock and synchronous active-high reset (read register only)
//   we/waddr/wdata  write port
//   re/raddr        read request; rdata updates on the following edge
//   rdata           registered read data, held while re is low
module chunk_ram
  import put_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int ENTRIES = P_DEPTH + 1,
  parameter int DATA_W  = P_CHUNK_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [ENTRIES];

  // Contents survive reset on purpose; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/level_streamer.sv
// Level sequencer for backward induction. Streams one tree level of option
// values (chunks 0..W, W = ceil((n-1)/LANES)) into the value buffer, collects
// the evaluator's write-backs for the next level into the same RAM and
// repeats until one node remains; that node is the price.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ld_valid/ld_addr/ld_data   terminal-level load (IDLE only)
//   start/num_nodes            begin pricing with n terminal nodes
//   s_valid/s_first/s_data     chunk stream to the value buffer
//   wb_valid/wb_data           evaluator write-backs, ascending chunk order
//   busy/done/price/steps/err  status and result
//
// state     | meaning
// ST_IDLE   | loads accepted, waiting for start
// ST_STREAM | issuing reads of chunks 0..W on consecutive cycles
// ST_DRAIN  | reads done, waiting for the level's last write-back
module level_streamer
  import put_pkg::*;
#(
  parameter int LANES  = P_LANES,
  parameter int WIDTH  = P_WIDTH,
  parameter int DEPTH  = P_DEPTH,
  parameter int ADDR_W = 5,
  parameter int NODE_W = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ld_valid,
  input  logic [ADDR_W-1:0]      ld_addr,
  input  logic [LANES*WIDTH-1:0] ld_data,
  input  logic                   start,
  input  logic [NODE_W-1:0]      num_nodes,
  output logic                   s_valid,
  output logic                   s_first,
  output logic [LANES*WIDTH-1:0] s_data,
  input  logic                   wb_valid,
  input  logic [LANES*WIDTH-1:0] wb_data,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       price,
  output logic [NODE_W-1:0]      steps,
  output logic                   err
);

  localparam int LOG_LANES = $clog2(LANES);

  state_t              state;
  logic [NODE_W-1:0]   n;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   wb_cnt;
  logic [ADDR_W-1:0]   lvl_w;

  logic                rd_en;
  logic                wb_take;
  logic                lvl_done;
  logic                n_ok;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [LANES*WIDTH-1:0] ram_wdata;

  // Highest chunk index read for a level of `nodes` values: ceil((nodes-1)/LANES).
  function automatic logic [ADDR_W-1:0] chunks_of(input logic [NODE_W-1:0] nodes);
    logic [NODE_W:0] t;
    t = {1'b0, nodes} + (NODE_W+1)'(LANES - 2);
    return ADDR_W'(t >> LOG_LANES);
  endfunction

  assign n_ok = ({1'b0, num_nodes} >= (NODE_W+1)'(2)) &&
                ({1'b0, num_nodes} <= (NODE_W+1)'(DEPTH * LANES));

  assign rd_en    = (state == ST_STREAM);
  assign wb_take  = wb_valid && (state != ST_IDLE) && (wb_cnt < lvl_w);
  assign lvl_done = wb_take && (state == ST_DRAIN) && (wb_cnt == lvl_w - ADDR_W'(1));

  // One write port shared between terminal-level loads (IDLE) and write-backs.
  // Reset gates it so an aborted run leaves the RAM untouched.
  assign ram_we    = !reset && (((state == ST_IDLE) && ld_valid && (ld_addr <= ADDR_W'(DEPTH)))
                                || wb_take);
  assign ram_waddr = (state == ST_IDLE) ? ld_addr : wb_cnt;
  assign ram_wdata = (state == ST_IDLE) ? ld_data : wb_data;

  chunk_ram #(
    .ADDR_W  (ADDR_W),
    .ENTRIES (DEPTH + 1),
    .DATA_W  (LANES * WIDTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (s_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      n       <= '0;
      rd_addr <= '0;
      wb_cnt  <= '0;
      lvl_w   <= '0;
      s_valid <= 1'b0;
      s_first <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      price   <= '0;
      steps   <= '0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      // s_valid/s_first track the RAM's 1-cycle read latency.
      s_valid <= rd_en;
      s_first <= rd_en && (rd_addr == '0);

      if (wb_valid && !wb_take) err <= 1'b1;
      if (wb_take) wb_cnt <= wb_cnt + ADDR_W'(1);

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (n_ok) begin
              n       <= num_nodes;
              lvl_w   <= chunks_of(num_nodes);
              steps   <= '0;
              rd_addr <= '0;
              wb_cnt  <= '0;
              busy    <= 1'b1;
              state   <= ST_STREAM;
            end else begin
              err <= 1'b1;
            end
          end
        end

        ST_STREAM: begin
          rd_addr <= rd_addr + ADDR_W'(1);
          if (rd_addr == lvl_w) state <= ST_DRAIN;
        end

        ST_DRAIN: begin
          if (lvl_done) begin
            n       <= n - NODE_W'(1);
            steps   <= steps + NODE_W'(1);
            rd_addr <= '0;
            wb_cnt  <= '0;
            if (n == NODE_W'(2)) begin
              price <= lane_of(wb_data, 0);
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              lvl_w <= chunks_of(n - NODE_W'(1));
              state <= ST_STREAM;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_level_streamer.sv
// Bench for level_streamer. An evaluator model (new = (up+down)/2, latency 3)
// answers the chunk stream; a stream monitor compares every streamed valid
// lane with an array-reduction reference of the tree; the directed sequence
// checks reset, timing, error handling and several full pricing runs.
module tb_level_streamer;

  localparam int LANES  = 32;
  localparam int WIDTH  = 64;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 5;
  localparam int NODE_W = 10;
  localparam int CW     = LANES * WIDTH;
  localparam int MAXN   = DEPTH * LANES;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ld_valid = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [CW-1:0]     ld_data = '0;
  logic              start = 1'b0;
  logic [NODE_W-1:0] num_nodes = '0;
  logic              s_valid, s_first;
  logic [CW-1:0]     s_data;
  logic              wb_valid = 1'b0;
  logic [CW-1:0]     wb_data = '0;
  logic              busy, done, err;
  logic [WIDTH-1:0]  price;
  logic [NODE_W-1:0] steps;

  level_streamer #(
    .LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NODE_W(NODE_W)
  ) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .num_nodes(num_nodes),
    .s_valid(s_valid), .s_first(s_first), .s_data(s_data),
    .wb_valid(wb_valid), .wb_data(wb_data),
    .busy(busy), .done(done), .price(price), .steps(steps), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] vals [MAXN];

  // evaluator + monitor state
  logic [CW-1:0] prev_chunk;
  logic [CW-1:0] pd [3];
  bit            pv [3];
  bit            ev_extra = 1'b0;
  longint        cyc = 0;
  longint        last_wb_cyc = 0;
  longint        done_cyc = 0;
  logic [63:0]   mref [MAXN];
  int            mn = 0;
  int            lvl_cnt = 0, cur_burst = 0, chunk_idx = 0, gaps = 0, bad_chunks = 0;
  int            bursts [$];
  bit            prev_sv = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_price(input int n);
    logic [63:0] a [MAXN];
    a = vals;
    for (int m = n; m > 1; m--)
      for (int i = 0; i < m - 1; i++) a[i] = (a[i] + a[i+1]) >> 1;
    return a[0];
  endfunction

  // Evaluator and stream monitor, both sampling at the falling edge.
  initial begin
    logic [CW-1:0] nc;
    logic [63:0]   a, b;
    bit            newv, bad;
    for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; pd[i] = '0; end
    prev_chunk = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        for (int i = 0; i < 3; i++) pv[i] = 1'b0;
        wb_valid = 1'b0;
        prev_sv  = 1'b0;
      end else begin
        if (done) done_cyc = cyc;
        newv = 1'b0;
        nc   = '0;
        if (s_valid) begin
          if (s_first) begin
            if (lvl_cnt > 0) begin
              bursts.push_back(cur_burst);
              for (int i = 0; i < mn - 1; i++) mref[i] = (mref[i] + mref[i+1]) >> 1;
              mn--;
            end
            lvl_cnt++;
            cur_burst = 1;
            chunk_idx = 0;
          end else begin
            if (!prev_sv) gaps++;
            cur_burst++;
            chunk_idx++;
            for (int l = 0; l < LANES; l++) begin
              a = prev_chunk[WIDTH*l +: WIDTH];
              b = (l < LANES - 1) ? prev_chunk[WIDTH*(l+1) +: WIDTH] : s_data[WIDTH-1:0];
              nc[WIDTH*l +: WIDTH] = (a + b) >> 1;
            end
            newv = 1'b1;
          end
          bad = 1'b0;
          for (int l = 0; l < LANES; l++) begin
            int idx;
            idx = chunk_idx * LANES + l;
            if (idx < mn && s_data[WIDTH*l +: WIDTH] !== mref[idx]) bad = 1'b1;
          end
          if (bad) bad_chunks++;
          prev_chunk = s_data;
        end
        prev_sv = s_valid;
        if (done) bursts.push_back(cur_burst);

        wb_valid = pv[2] | ev_extra;
        wb_data  = pv[2] ? pd[2] : {CW{1'b1}};
        if (wb_valid) last_wb_cyc = cyc;
        ev_extra = 1'b0;
        pv[2] = pv[1]; pd[2] = pd[1];
        pv[1] = pv[0]; pd[1] = pd[0];
        pv[0] = newv;  pd[0] = nc;
      end
    end
  end

  task automatic gen_vals();
    for (int i = 0; i < MAXN; i++) vals[i] = {$urandom, $urandom} >> 2;
  endtask

  task automatic load_ram(input int n);
    logic [CW-1:0] c;
    for (int ch = 0; ch <= DEPTH; ch++) begin
      for (int l = 0; l < LANES; l++) begin
        int idx;
        idx = ch * LANES + l;
        c[WIDTH*l +: WIDTH] = (idx < n) ? vals[idx] : {$urandom, $urandom};
      end
      @(negedge clk);
      ld_valid = 1'b1;
      ld_addr  = ch[ADDR_W-1:0];
      ld_data  = c;
    end
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic arm(input int n);
    for (int i = 0; i < MAXN; i++) mref[i] = vals[i];
    mn = n; lvl_cnt = 0; cur_burst = 0; chunk_idx = 0;
    gaps = 0; bad_chunks = 0;
    bursts.delete();
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    start = 1'b1;
    num_nodes = n[NODE_W-1:0];
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int k);
    @(negedge clk);
    reset = 1'b1;
    repeat (k) @(negedge clk);
    reset = 1'b0;
  endtask

  // Checks a completed run against the reference: price, steps, per-level
  // burst lengths, gap-free streaming, streamed lane contents, done timing.
  task automatic finish_run(input int n, input string tag, input logic [63:0] exp);
    bit ok;
    int bad_b;
    wait_done(30000, ok);
    chk({tag, " done_seen"}, 64'(ok), 64'd1);
    @(negedge clk);
    @(negedge clk);
    chk({tag, " price"}, price, exp);
    chk({tag, " steps"}, 64'(steps), 64'(n - 1));
    chk({tag, " busy_after"}, 64'(busy), 64'd0);
    chk({tag, " done_latency"}, 64'(done_cyc - last_wb_cyc), 64'd1);
    chk({tag, " levels"}, 64'(bursts.size()), 64'(n - 1));
    bad_b = 0;
    foreach (bursts[k]) begin
      int m;
      m = n - k;
      if (bursts[k] != (m - 1 + LANES - 1) / LANES + 1) bad_b++;
    end
    chk({tag, " burst_len_bad"}, 64'(bad_b), 64'd0);
    chk({tag, " gaps"}, 64'(gaps), 64'd0);
    chk({tag, " bad_chunks"}, 64'(bad_chunks), 64'd0);
  endtask

  task automatic full_run(input int n, input string tag);
    logic [63:0] exp;
    gen_vals();
    load_ram(n);
    arm(n);
    exp = ref_price(n);
    do_start(n);
    finish_run(n, tag, exp);
    chk({tag, " err"}, 64'(err), 64'd0);
  endtask

  initial begin
    bit saw_sv;
    logic [63:0] exp, held;
    int rn;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst s_valid", 64'({s_valid, s_first}), 64'd0);
    chk("rst s_data", 64'(|s_data), 64'd0);
    chk("rst done_err", 64'({done, err}), 64'd0);
    chk("rst price", price, 64'd0);
    chk("rst steps", 64'(steps), 64'd0);
    reset = 1'b0;

    // n=2, lanes {10,20}
    gen_vals();
    vals[0] = 64'd10;
    vals[1] = 64'd20;
    load_ram(2);
    arm(2);
    do_start(2);
    chk("n2 busy_rise", 64'({busy, s_valid}), 64'b10);
    @(negedge clk);
    chk("n2 first_beat", 64'({s_valid, s_first}), 64'b11);
    chk("n2 lane0", s_data[63:0], 64'd10);
    chk("n2 lane1", s_data[127:64], 64'd20);
    @(negedge clk);
    chk("n2 second_beat", 64'({s_valid, s_first}), 64'b10);
    @(negedge clk);
    chk("n2 stream_end", 64'(s_valid), 64'd0);
    finish_run(2, "n2", 64'd15);

    // out-of-range start
    @(negedge clk);
    start = 1'b1; num_nodes = 10'd1;
    @(negedge clk);
    start = 1'b0;
    saw_sv = 1'b0;
    repeat (5) begin saw_sv |= s_valid | busy; @(negedge clk); end
    chk("n1 err", 64'(err), 64'd1);
    chk("n1 no_activity", 64'(saw_sv), 64'd0);
    do_reset(2);
    @(negedge clk);
    chk("err cleared", 64'(err), 64'd0);
    start = 1'b1; num_nodes = 10'd513;
    @(negedge clk);
    start = 1'b0;
    saw_sv = 1'b0;
    repeat (5) begin saw_sv |= s_valid | busy; @(negedge clk); end
    chk("n513 err", 64'(err), 64'd1);
    chk("n513 no_activity", 64'(saw_sv), 64'd0);
    do_reset(2);

    // full runs
    full_run(33, "n33");
    full_run(65, "n65");
    rn = $urandom_range(100, 511);
    full_run(rn, "nrand");
    full_run(MAXN, "n512");

    // reset mid-run, then a fresh run
    gen_vals();
    load_ram(200);
    arm(200);
    do_start(200);
    repeat (40) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst busy_sv", 64'({busy, s_valid, s_first, done}), 64'd0);
    chk("mid_rst s_data", 64'(|s_data), 64'd0);
    chk("mid_rst price_steps", 64'({price[31:0], 22'd0, steps}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_rst quiet", 64'({busy, s_valid, err}), 64'd0);
    full_run($urandom_range(100, 300), "after_rst");

    // start/ld while busy ignored; stray write-back after completion flagged
    gen_vals();
    load_ram(40);
    arm(40);
    exp = ref_price(40);
    do_start(40);
    repeat (5) @(negedge clk);
    start = 1'b1; num_nodes = 10'd7;
    ld_valid = 1'b1; ld_addr = '0; ld_data = {64{32'hDEAD_BEEF}};
    @(negedge clk);
    start = 1'b0; ld_valid = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1; num_nodes = 10'd3;
    ld_valid = 1'b1; ld_addr = 5'd1; ld_data = {64{32'h1234_5678}};
    @(negedge clk);
    start = 1'b0; ld_valid = 1'b0;
    finish_run(40, "busy_ign", exp);
    chk("busy_ign err", 64'(err), 64'd0);
    held = price;
    ev_extra = 1'b1;
    repeat (3) @(negedge clk);
    chk("extra_wb err", 64'(err), 64'd1);
    chk("extra_wb price", price, exp);
    chk("extra_wb busy", 64'(busy), 64'd0);
    chk("extra_wb price_held", price, held);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
